// File: rtl/pattern_det_multi_pkg.sv
// Shared constants and helpers for the
// multi-channel serial pattern detector.
package pattern_det_multi_pkg;

  localparam logic MODE_OVERLAP    = 1'b0;
  localparam logic MODE_NONOVERLAP = 1'b1;

  function automatic int fill_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_det_chan.sv
// One detector channel: history shift register,
// fill tracker, pattern compare and match counter.
module pattern_det_chan
  import pattern_det_multi_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic             s_i,
  input  logic             clr_i,
  output logic             match_o,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam int FW = fill_w(PATTERN_W);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [PATTERN_W-2:0] hist_q, hist_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                 match_q, match_d;
  logic                 sat_q, sat_d;
  logic [PATTERN_W-1:0] win;
  logic                 hit;

  always_comb begin
    win     = {hist_q, bit_i};
    hit     = (fill_q == FULL) && (win == PATTERN);
    cnt_inc = cnt_q + 1'b1;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (en_i) begin
      match_d = hit;
      hist_d  = win[PATTERN_W-2:0];
      unique case (1'b1)
        hit && (s_i == MODE_NONOVERLAP): fill_d = '0;
        fill_q != FULL: fill_d = fill_q + 1'b1;
        default: ;
      endcase
    end
    // clear wins over a coincident hit; the pulse still goes out
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en_i && hit && cnt_q != CMAX) begin
      cnt_d = cnt_inc;
      if (cnt_inc == CMAX) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign match_o = match_q;
  assign count_o = cnt_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/pattern_det_multi.sv
// Multi-channel serial pattern detector with
// per-channel saturating match counters.
module pattern_det_multi
  import pattern_det_multi_pkg::*;
#(
  parameter int                   CH        = 2,
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CH-1:0]       i,
  input  logic                s,
  input  logic                clr,
  output logic [CH-1:0]       match,
  output logic [CH*CNT_W-1:0] count,
  output logic [CH-1:0]       sat
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pattern_det_chan #(
      .PATTERN_W (PATTERN_W),
      .PATTERN   (PATTERN),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en),
      .bit_i   (i[k]),
      .s_i     (s),
      .clr_i   (clr),
      .match_o (match[k]),
      .count_o (count[k*CNT_W +: CNT_W]),
      .sat_o   (sat[k])
    );
  end

endmodule

// File: tb/tb_pattern_det_multi.sv
// Directed and random checks for pattern_det_multi.
module tb_pattern_det_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 0, s0 = 0, clr0 = 0;
  logic [1:0]  i0 = '0, match0, sat0;
  logic [15:0] count0;

  logic        en1 = 0, s1 = 0, clr1 = 0;
  logic [0:0]  i1 = '0, match1, sat1;
  logic [1:0]  count1;

  logic        en2 = 0, s2 = 0, clr2 = 0;
  logic [2:0]  i2 = '0, match2, sat2;
  logic [23:0] count2;

  pattern_det_multi u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .i(i0),
    .s(s0), .clr(clr0), .match(match0),
    .count(count0), .sat(sat0));

  pattern_det_multi #(
    .CH(1), .PATTERN_W(4), .PATTERN(4'b1111), .CNT_W(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .i(i1),
    .s(s1), .clr(clr1), .match(match1),
    .count(count1), .sat(sat1));

  pattern_det_multi #(.CH(3)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .i(i2),
    .s(s2), .clr(clr2), .match(match2),
    .count(count2), .sat(sat2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] i;
    logic       s;
    logic       clr;
    logic [1:0] m;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic en, input logic [1:0] i,
                     input logic s, input logic clr,
                     input logic [1:0] m, input logic [7:0] c0);
    vec_t v;
    v.en = en; v.i = i; v.s = s; v.clr = clr;
    v.m = m; v.c0 = c0; v.c1 = 8'd0;
    vq.push_back(v);
  endtask

  // reference model for u2
  logic [2:0] mh[3];
  int         mf[3];
  int         mc[3];
  logic       ms[3];
  logic       mm[3];

  initial begin
    logic [3:0] w;
    logic       h;
    logic [1:0] c1e[8];
    logic       s1e[8];

    // overlapping: 1,0,1,1,0,1,1
    add(1,2'b01,0,0,2'b00,0); add(1,2'b00,0,0,2'b00,0);
    add(1,2'b01,0,0,2'b00,0); add(1,2'b01,0,0,2'b01,1);
    add(1,2'b00,0,0,2'b00,1); add(1,2'b01,0,0,2'b00,1);
    add(1,2'b01,0,0,2'b01,2);
    // non-overlapping, same stream
    add(1,2'b01,1,0,2'b00,2); add(1,2'b00,1,0,2'b00,2);
    add(1,2'b01,1,0,2'b00,2); add(1,2'b01,1,0,2'b01,3);
    add(1,2'b00,1,0,2'b00,3); add(1,2'b01,1,0,2'b00,3);
    add(1,2'b01,1,0,2'b00,3);
    // 1,0,1, three disabled cycles, then 1
    add(1,2'b01,0,0,2'b00,3); add(1,2'b00,0,0,2'b00,3);
    add(1,2'b01,0,0,2'b00,3); add(0,2'b01,0,0,2'b00,3);
    add(0,2'b11,0,0,2'b00,3); add(0,2'b01,0,0,2'b00,3);
    add(1,2'b01,0,0,2'b01,4);
    // clear on the hit edge
    add(1,2'b00,0,0,2'b00,4); add(1,2'b01,0,0,2'b00,4);
    add(1,2'b01,0,1,2'b01,0);
    // count again, then clear while disabled
    add(1,2'b00,0,0,2'b00,0); add(1,2'b01,0,0,2'b00,0);
    add(1,2'b01,0,0,2'b01,1); add(0,2'b01,0,1,2'b00,0);

    #12;
    check("rst_match", 32'(match0), 0);
    check("rst_count", 32'(count0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[n]) begin
      en0 = vq[n].en; i0 = vq[n].i;
      s0 = vq[n].s; clr0 = vq[n].clr;
      step();
      check($sformatf("v%0d_match", n), 32'(match0), 32'(vq[n].m));
      check($sformatf("v%0d_cnt0", n), 32'(count0[7:0]), 32'(vq[n].c0));
      check($sformatf("v%0d_cnt1", n), 32'(count0[15:8]), 32'(vq[n].c1));
    end
    check("tbl_sat", 32'(sat0), 0);

    // build count to 5, then async reset mid-stream
    en0 = 1; s0 = 0; clr0 = 0;
    for (int r = 0; r < 5; r++) begin
      i0 = 2'b01; step(); i0 = 2'b00; step();
      i0 = 2'b01; step(); i0 = 2'b01; step();
    end
    check("pre_rst_cnt", 32'(count0[7:0]), 5);
    check("pre_rst_match", 32'(match0), 1);
    i0 = 2'b01; step(); i0 = 2'b00; step();
    i0 = 2'b01; step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(count0), 0);
    check("arst_match", 32'(match0), 0);
    check("arst_sat", 32'(sat0), 0);
    #1 rst_n = 1'b1;
    i0 = 2'b01; step();
    check("post_rst_1", 32'(match0), 0);
    i0 = 2'b00; step();
    i0 = 2'b01; step();
    check("post_rst_3", 32'(match0), 0);
    i0 = 2'b01; step();
    check("post_rst_4", 32'(match0), 1);
    check("post_rst_cnt", 32'(count0[7:0]), 1);
    en0 = 0;

    // saturation on 2-bit counter, pattern 1111
    c1e = '{0, 0, 0, 1, 2, 3, 3, 3};
    s1e = '{0, 0, 0, 0, 0, 1, 1, 1};
    en1 = 1; s1 = 0; i1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      check($sformatf("sat_cnt%0d", n), 32'(count1), 32'(c1e[n]));
      check($sformatf("sat_flag%0d", n), 32'(sat1), 32'(s1e[n]));
      check($sformatf("sat_m%0d", n), 32'(match1), 32'(n >= 3));
    end
    en1 = 0; clr1 = 1; step(); clr1 = 0;
    check("sat_clr_cnt", 32'(count1), 0);
    check("sat_clr_flag", 32'(sat1), 0);

    // random independent channels
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; mf[k] = 0; mc[k] = 0; ms[k] = 0; mm[k] = 0;
    end
    for (int n = 0; n < 1000; n++) begin
      en2  = ($urandom_range(3) != 0);
      s2   = 1'($urandom_range(1));
      clr2 = ($urandom_range(63) == 0);
      i2   = 3'($urandom_range(7));
      for (int k = 0; k < 3; k++) begin
        w = {mh[k], i2[k]};
        h = (mf[k] == 3) && (w == 4'b1011);
        mm[k] = en2 && h;
        if (en2) begin
          mh[k] = w[2:0];
          if (h && s2) mf[k] = 0;
          else if (mf[k] < 3) mf[k]++;
        end
        if (clr2) begin
          mc[k] = 0; ms[k] = 0;
        end else if (en2 && h && mc[k] < 255) begin
          mc[k]++;
          if (mc[k] == 255) ms[k] = 1;
        end
      end
      step();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rnd%0d_m%0d", n, k),
              32'(match2[k]), 32'(mm[k]));
        check($sformatf("rnd%0d_c%0d", n, k),
              32'(count2[k*8 +: 8]), 32'(mc[k]));
        check($sformatf("rnd%0d_s%0d", n, k),
              32'(sat2[k]), 32'(ms[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
